gbuf_p_reader: RTL
==================

Name: gbuf_p_reader

Overview:
- Drains the product matrix from global buffer P to the host after the mm controller signals valid.
- Acts as the read-side counterpart of the controller's P write port.
- Issues sequential BRAM reads, which have 1-cycle read latency, from a base address for a programmed word count.
- Emits the words on a valid/ready stream with last-beat marking, and handles full backpressure without losing or duplicating words.

Parameters:
- DATA_WIDTH, 256, width of one P buffer word (8 lanes x 32 bit).
- RD_LAT, 1, P buffer read latency in cycles; only 1 is supported.
- FIFO_DEPTH, 2, output skid FIFO entries; must be at least RD_LAT+1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  level start; sampled in IDLE
- done_o  out  1  high in DONE until start_i falls
- base_addr_i  in  `ADDR_WIDTH  first P word address; sampled at start
- len_i  in  `ADDR_WIDTH  number of words to drain; sampled at start
- enp_o  out  1  P buffer enable
- wep_o  out  1  P buffer write enable, constant 0
- addrp_o  out  `ADDR_WIDTH  P buffer read address
- datap_i  in  DATA_WIDTH  P buffer read data, valid RD_LAT cycles after enp_o
- tdata_o  out  DATA_WIDTH  stream data
- tvalid_o  out  1  stream valid
- tready_i  in  1  stream ready
- tlast_o  out  1  marks the final word

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-low.
- Reset values: state IDLE; done_o, enp_o, wep_o, tvalid_o and tlast_o all 0; addrp_o 0; tdata_o 0; all counters and the FIFO cleared.
- Reset asserted mid-transfer aborts immediately. In-flight reads are discarded, and no beat appears after rst_ni deasserts.

- State machine, states IDLE, READ, FLUSH, DONE:
  - IDLE -> READ when start_i=1 and len_i!=0. On this transition, latch base_addr_i into rd_addr, latch len_i into rd_left and tx_left.
  - IDLE -> DONE when start_i=1 and len_i==0. No reads are issued and no beats are sent.
  - READ -> FLUSH in the cycle the last read issues (rd_left becomes 0).
  - FLUSH -> DONE on the cycle the last beat handshakes (tvalid_o & tready_i & tlast_o).
  - DONE -> IDLE when start_i=0.
  - start_i changes while in READ or FLUSH are ignored.
  - base_addr_i and len_i changes after start are ignored.

- Read issue:
  - enp_o=1 in READ only when credit is available: inflight + fifo_count - pop < FIFO_DEPTH, where pop = tvalid_o & tready_i.
  - addrp_o = rd_addr during an issue. rd_addr increments by 1 per issue and wraps modulo 2^`ADDR_WIDTH.
  - When enp_o=0, addrp_o holds its last value.

- Return path:
  - inflight is a 1-bit register equal to enp_o delayed by RD_LAT.
  - When inflight=1, datap_i is pushed into the FIFO that cycle.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full-by-credit.

- Stream interface:
  - tvalid_o = FIFO not empty.
  - tdata_o = FIFO head.
  - tlast_o = tvalid_o & (tx_left==1).
  - tx_left decrements on each handshake.
  - While tvalid_o & !tready_i, tdata_o and tlast_o are held stable.
  - tvalid_o never drops without a handshake.

- Throughput: with tready_i held at 1, one beat per cycle sustained. The first beat appears 2 cycles after the IDLE->READ transition (read issue + BRAM latency).

- Width rule: rd_left and tx_left are `ADDR_WIDTH wide. len_i = 2^`ADDR_WIDTH - 1 is legal.

- Overlap: while the FIFO is full and tready_i=0, enp_o stays 0. No read is ever issued whose data lacks a FIFO slot.

Decomposition:
- `ADDR_WIDTH and the state encodings (IDLE/READ/FLUSH/DONE, matching the controller's 2-bit IDLE/BUSY/DONE/WAIT style) live in def.v.
- DATA_WIDTH default also lives in def.v.
- One sub-module, skid_fifo: parameterised DATA_WIDTH and DEPTH. Ports: push, din, pop, dout, empty, count. Async active-low reset; same-cycle push/pop supported.

Test Plan:
- Basic drain, no backpressure: base=0x10, len=5, tready=1 -> addrp 0x10..0x14 on 5 consecutive enp cycles; 5 beats, data matching memory, tlast on beat 5; done_o 1 until start_i=0, then IDLE.
- Zero length: len=0 -> enp_o never asserts; tvalid never asserts; done_o=1 the cycle after start.
- Backpressure: len=8, tready toggling with a random 30% duty, including holding 0 for 10 cycles -> exactly 8 beats in order; tdata stable while stalled; enp_o count equals 8; FIFO never overflows (assertion).
- Address wrap: base=2^`ADDR_WIDTH-2, len=4 -> addresses max-1, max, 0, 1.
- Reset mid-transfer: len=16, assert rst_ni low after beat 6 -> all outputs return to reset values asynchronously. A following start with len=3 drains exactly 3 fresh words.
- Start held and level changes: start_i held high through DONE, then base_addr_i changed during READ -> no restart; addresses follow the latched base. done_o drops one cycle after start_i falls.

Source files
------------

// File: rtl/gbuf_p_reader_pkg.sv
// Shared widths and state encoding for the global buffer P reader.
package gbuf_p_reader_pkg;

  localparam int unsigned ADDR_WIDTH     = 8;
  localparam int unsigned DATA_WIDTH_DEF = 256;

  // Same 2-bit style as the mm controller's IDLE/BUSY/DONE/WAIT encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/gbuf_p_reader_skid_fifo.sv
// Small output FIFO absorbing read data that returns while the stream is stalled.
module gbuf_p_reader_skid_fifo #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [DATA_WIDTH-1:0]          din_i,
  input  logic                           pop_i,
  output logic [DATA_WIDTH-1:0]          dout_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CntW'(1);
      else if (pop_i && !push_i) cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/gbuf_p_reader.sv
// Drains a block of words from global buffer P onto a valid/ready stream with
// credit-based read issue so no returning word ever lacks a FIFO slot.
module gbuf_p_reader
  import gbuf_p_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  done_o,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  enp_o,
  output logic                  wep_o,
  output logic [ADDR_WIDTH-1:0] addrp_o,
  input  logic [DATA_WIDTH-1:0] datap_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] rd_left_q, rd_left_d;
  logic [ADDR_WIDTH-1:0] tx_left_q, tx_left_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [RD_LAT-1:0]     inflight_q;

  logic                  fifo_empty;
  logic [CntW-1:0]       fifo_count;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  pop, push, enp;
  logic [31:0]           used;

  assign tvalid_o = !fifo_empty;
  assign pop      = tvalid_o & tready_i;
  assign push     = inflight_q[RD_LAT-1];

  // Slots already claimed by outstanding reads and queued words, net of this cycle's pop.
  assign used = 32'($countones(inflight_q)) + 32'(fifo_count) - 32'(pop);
  assign enp  = (state_q == StRead) && (used < FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    tx_left_d   = tx_left_q;
    addr_hold_d = addr_hold_q;
    if (pop) tx_left_d = tx_left_q - ADDR_WIDTH'(1);
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d   = StRead;
            rd_addr_d = base_addr_i;
            rd_left_d = len_i;
            tx_left_d = len_i;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRead: begin
        if (enp) begin
          rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
          rd_left_d   = rd_left_q - ADDR_WIDTH'(1);
          addr_hold_d = rd_addr_q;
          if (rd_left_q == ADDR_WIDTH'(1)) state_d = StFlush;
        end
      end
      StFlush: if (pop && tlast_o) state_d = StDone;
      StDone:  if (!start_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      tx_left_q   <= '0;
      addr_hold_q <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      tx_left_q   <= tx_left_d;
      addr_hold_q <= addr_hold_d;
      inflight_q[0] <= enp;
      for (int i = 1; i < int'(RD_LAT); i++) inflight_q[i] <= inflight_q[i-1];
    end
  end

  gbuf_p_reader_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (datap_i),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign enp_o   = enp;
  assign wep_o   = 1'b0;
  assign addrp_o = enp ? rd_addr_q : addr_hold_q;
  assign tdata_o = fifo_dout;
  assign tlast_o = tvalid_o && (tx_left_q == ADDR_WIDTH'(1));
  assign done_o  = (state_q == StDone);

endmodule
